// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: fetch PC sequencer with branch redirect and IF/ID squash; branch statistics built only when BR_STATS_EN is defined
module pc_branch_ctrl #(
  parameter int              PC_W         = 16,
  parameter logic [PC_W-1:0] RESET_VEC    = '0,
  parameter int              PC_STEP      = 1,
  parameter int              FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            imem_ready,
  input  logic            id_stall,
  input  logic            id_is_branch,
  input  logic [PC_W-1:0] id_pc,
  input  logic            branch_signal,
  input  logic [PC_W-1:0] branch_offset,
  output logic [PC_W-1:0] pc,
  output logic            ifid_write,
  output logic            flush_ifid,
  output logic            redirect,
  output logic [15:0]     br_count,
  output logic [15:0]     br_taken_count
);
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] MISS  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  logic [1:0]      state, state_nx;
  logic [1:0]      cnt, cnt_nx;
  logic [PC_W-1:0] pc_nx;
  logic            in_flush, resolve, taken;
  // ID holds a bubble while flushing, so any branch seen then is ignored
  assign in_flush = state == FLUSH;
  assign resolve  = id_is_branch & ~id_stall & ~in_flush;
  assign taken    = resolve & branch_signal;
  // IF/ID control; forced low while reset is held
  always_comb begin
    redirect   = reset_n & taken;
    flush_ifid = reset_n & (taken | in_flush | (~id_stall & ~imem_ready));
    ifid_write = reset_n & ~taken & ~in_flush & ~id_stall & imem_ready;
  end
  // next PC / state: taken > flush > stall > fetch ready > miss
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pc_nx    = pc;
    if (taken) begin
      pc_nx    = id_pc + branch_offset;
      state_nx = FLUSH_CYCLES > 1 ? FLUSH : RUN;
      cnt_nx   = 2'(FLUSH_CYCLES - 1);
    end else if (in_flush) begin
      cnt_nx   = cnt - 2'd1;
      state_nx = cnt == 2'd1 ? RUN : FLUSH;
    end else if (!id_stall) begin
      pc_nx    = imem_ready ? pc + PC_W'(PC_STEP) : pc;
      state_nx = imem_ready ? RUN : MISS;
    end
  end
  // PC and FSM registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc    <= RESET_VEC;
      state <= RUN;
      cnt   <= '0;
    end else begin
      pc    <= pc_nx;
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
`ifdef BR_STATS_EN
  // saturating resolved / taken branch counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_count       <= '0;
      br_taken_count <= '0;
    end else begin
      if (resolve && br_count != 16'hFFFF) br_count <= br_count + 16'd1;
      if (taken && br_taken_count != 16'hFFFF) br_taken_count <= br_taken_count + 16'd1;
    end
  end
`else
  assign br_count       = '0;
  assign br_taken_count = '0;
`endif
endmodule

// File: tb/tb_pc_branch_ctrl.sv
// tb_pc_branch_ctrl: directed vectors for pc_branch_ctrl (default and 3-cycle flush instances)
module tb_pc_branch_ctrl;
  logic        clk = 0;
  logic        reset_n, imem_ready, id_stall, id_is_branch, branch_signal;
  logic [15:0] id_pc, branch_offset;
  logic [15:0] pc, pc3, brc, btc, brc3, btc3;
  logic        ifid_write, flush_ifid, redirect, ifid3, flush3, redirect3;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  pc_branch_ctrl dut (
    .clk(clk), .reset_n(reset_n), .imem_ready(imem_ready), .id_stall(id_stall),
    .id_is_branch(id_is_branch), .id_pc(id_pc), .branch_signal(branch_signal),
    .branch_offset(branch_offset), .pc(pc), .ifid_write(ifid_write),
    .flush_ifid(flush_ifid), .redirect(redirect), .br_count(brc), .br_taken_count(btc)
  );

  pc_branch_ctrl #(.FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .imem_ready(imem_ready), .id_stall(id_stall),
    .id_is_branch(id_is_branch), .id_pc(id_pc), .branch_signal(branch_signal),
    .branch_offset(branch_offset), .pc(pc3), .ifid_write(ifid3),
    .flush_ifid(flush3), .redirect(redirect3), .br_count(brc3), .br_taken_count(btc3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic br, input logic sig, input logic [15:0] ipc, input logic [15:0] off);
    id_is_branch  = br;
    branch_signal = sig;
    id_pc         = ipc;
    branch_offset = off;
  endtask

  task automatic do_reset;
    reset_n = 0;
    #1;
    reset_n = 1;
    #1;
  endtask

  logic [4:0] pat;
  logic [15:0] exp_br, exp_tk;

  initial begin
    reset_n = 0; imem_ready = 1; id_stall = 0;
    branch(0, 0, 16'h0, 16'h0);
    #12;
    check("rst_pc", pc, 16'h0000);
    check("rst_ifid", ifid_write, 0);
    check("rst_flush", flush_ifid, 0);
    check("rst_redirect", redirect, 0);
    check("rst_brc", brc, 0);
    reset_n = 1;
    #1;
    check("t1_pc0", pc, 16'h0000);
    check("t1_ifid0", ifid_write, 1);
    tick;
    check("t1_pc1", pc, 16'h0001);
    check("t1_ifid1", ifid_write, 1);
    tick;
    check("t1_pc2", pc, 16'h0002);
    check("t1_ifid2", ifid_write, 1);

    branch(1, 1, 16'h0010, 16'hFFFC);
    #1;
    check("t2_redirect", redirect, 1);
    check("t2_flush", flush_ifid, 1);
    check("t2_ifid", ifid_write, 0);
    tick;
    check("t2_target", pc, 16'h000C);
    branch(1, 0, 16'h0010, 16'hFFFC);
    #1;
    check("t2_nt_redirect", redirect, 0);
    check("t2_nt_flush", flush_ifid, 0);
    tick;
    check("t2_nt_pc", pc, 16'h000D);

    id_stall = 1;
    branch(1, 1, 16'h0010, 16'h0020);
    #1;
    check("t3_stall_redirect", redirect, 0);
    check("t3_stall_flush", flush_ifid, 0);
    check("t3_stall_ifid", ifid_write, 0);
    tick;
    check("t3_stall_pc", pc, 16'h000D);
    id_stall = 0;
    #1;
    check("t3_redirect", redirect, 1);
    tick;
    check("t3_target", pc, 16'h0030);
    branch(0, 0, 16'h0, 16'h0);

    do_reset;
    check("t4_rst_pc", pc, 16'h0000);
    for (int i = 0; i < 5; i++) tick;
    check("t4_pc5", pc, 16'h0005);
    imem_ready = 0;
    #1;
    check("t4_miss_flush", flush_ifid, 1);
    check("t4_miss_ifid", ifid_write, 0);
    tick;
    check("t4_miss_pc", pc, 16'h0005);
    branch(1, 1, 16'h0030, 16'h0010);
    #1;
    check("t4_redirect", redirect, 1);
    check("t4_taken_ifid", ifid_write, 0);
    tick;
    check("t4_target", pc, 16'h0040);
    branch(0, 0, 16'h0, 16'h0);
    #1;
    check("t4_miss3_ifid", ifid_write, 0);
    check("t4_miss3_flush", flush_ifid, 1);
    tick;
    check("t4_miss3_pc", pc, 16'h0040);
    imem_ready = 1;
    #1;
    check("t4_ready_ifid", ifid_write, 1);
    check("t4_ready_flush", flush_ifid, 0);
    tick;
    check("t4_step", pc, 16'h0041);

    do_reset;
    branch(1, 1, 16'hFFFF, 16'h0002);
    #1;
    check("t5_redirect3", redirect3, 1);
    check("t5_flush3_c0", flush3, 1);
    tick;
    check("t5_wrap_pc3", pc3, 16'h0001);
    check("t5_wrap_pc", pc, 16'h0001);
    branch(0, 0, 16'h0, 16'h0);
    #1;
    check("t5_flush3_c1", flush3, 1);
    check("t5_ifid3_c1", ifid3, 0);
    tick;
    check("t5_hold_pc3", pc3, 16'h0001);
    branch(1, 1, 16'h0100, 16'h0000);
    #1;
    check("t5_flush3_c2", flush3, 1);
    check("t5_ignored_redirect3", redirect3, 0);
    tick;
    branch(0, 0, 16'h0, 16'h0);
    #1;
    check("t5_ignored_pc3", pc3, 16'h0001);
    check("t5_flush3_done", flush3, 0);
    check("t5_ifid3_run", ifid3, 1);
    tick;
    check("t5_step_pc3", pc3, 16'h0002);

    branch(1, 1, 16'hFFF0, 16'h000F);
    tick;
    branch(0, 0, 16'h0, 16'h0);
    check("wrap_pc_ffff", pc, 16'hFFFF);
    tick;
    check("wrap_pc_0000", pc, 16'h0000);

    do_reset;
    pat = 5'b01001;
    for (int i = 0; i < 5; i++) begin
      branch(1, pat[i], 16'h0020, 16'h0000);
      tick;
    end
    id_stall = 1;
    branch(1, 1, 16'h0020, 16'h0000);
    tick;
    id_stall = 0;
    branch(0, 0, 16'h0, 16'h0);
    #1;
`ifdef BR_STATS_EN
    exp_br = 16'd5; exp_tk = 16'd2;
`else
    exp_br = 16'd0; exp_tk = 16'd0;
`endif
    check("t6_br_count", brc, exp_br);
    check("t6_taken_count", btc, exp_tk);
`ifdef BR_STATS_EN
    branch(1, 1, 16'h0020, 16'h0000);
    for (int i = 0; i < 65540; i++) tick;
    branch(0, 0, 16'h0, 16'h0);
    check("t6_br_sat", brc, 16'hFFFF);
    check("t6_taken_sat", btc, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
